led_pattern_sequencer: RTL

Controller that drives the 8-bit board LED bank from a programmable sequence of patterns instead of a fixed toggle. A small register file holds up to DEPTH steps (pattern + duration in ticks). On `start`, the block plays steps 0..`cfg_last`, once or looping, using a tick prescaler derived from CLK_FREQ. It sits between the top-level configuration/control logic and the `leds` pins.

---
 rtl/led_seq_pkg.sv | 11 +
 rtl/led_pattern_sequencer_if.sv | 30 +++
 rtl/tick_gen.sv | 28 ++
 rtl/led_pattern_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

  localparam int unsigned LED_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Configuration/control and LED-drive bundle between the control logic and the sequencer.
interface led_pattern_sequencer_if #(
  parameter int unsigned AW    = 3,
  parameter int unsigned DUR_W = 12
);

  logic                            cfg_we;
  logic [AW-1:0]                   cfg_addr;
  logic [led_seq_pkg::LED_W-1:0]   cfg_pattern;
  logic [DUR_W-1:0]                cfg_dur;
  logic [AW-1:0]                   cfg_last;
  logic                            loop;
  logic                            start;
  logic                            stop;
  logic                            busy;
  logic                            done;
  logic [AW-1:0]                   step_idx;
  logic [led_seq_pkg::LED_W-1:0]   leds;

  modport master (
    output cfg_we, cfg_addr, cfg_pattern, cfg_dur, cfg_last, loop, start, stop,
    input  busy, done, step_idx, leds
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_pattern, cfg_dur, cfg_last, loop, start, stop,
    output busy, done, step_idx, leds
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: registered one-cycle tick every CLK_FREQ/TICK_HZ cycles.
module tick_gen #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned TICK_HZ  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned CW       = $clog2(TICK_DIV);

  logic [CW-1:0] count;

  // tick is set one edge early so it is high exactly while count == TICK_DIV-1
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= (count == CW'(TICK_DIV - 1)) ? '0 : count + CW'(1);
      tick  <= (count == CW'(TICK_DIV - 2));
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Plays a programmable list of {pattern, duration} steps onto the LED bank, once or looping.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DUR_W    = 12
) (
  input logic                    clk,
  input logic                    rst,
  led_pattern_sequencer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [LED_W-1:0] pattern;
    logic [DUR_W-1:0] dur;
  } step_t;

  step_t            mem [DEPTH];
  seq_state_t       state_q, state_d;
  logic [AW-1:0]    step_q, step_d, last_q, last_d, nxt_idx_c;
  logic             loop_q, loop_d, busy_q, busy_d, done_q, done_d;
  logic [LED_W-1:0] leds_q, leds_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             tick, clr_c, we_c;
  step_t            ld_c;

  function automatic logic [DUR_W-1:0] dur_floor(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  tick_gen #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_c),
    .tick (tick)
  );

  assign nxt_idx_c = (step_q < last_q) ? step_q + AW'(1) : '0;
  assign ld_c      = mem[nxt_idx_c];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and next-output logic; stop has priority over any tick/advance
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    loop_d  = loop_q;
    leds_d  = leds_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rem_d   = rem_q;
    clr_c   = 1'b0;
    we_c    = 1'b0;
    case (state_q)
      IDLE: begin
        we_c = bus.cfg_we;
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          last_d  = bus.cfg_last;
          loop_d  = bus.loop;
          step_d  = '0;
          leds_d  = mem[0].pattern;
          rem_d   = dur_floor(mem[0].dur);
          busy_d  = 1'b1;
          clr_c   = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          leds_d  = '0;
          busy_d  = 1'b0;
          step_d  = '0;
        end else if (tick) begin
          if (rem_q == DUR_W'(1)) begin
            if ((step_q < last_q) || loop_q) begin
              step_d = nxt_idx_c;
              leds_d = ld_c.pattern;
              rem_d  = dur_floor(ld_c.dur);
            end else begin
              state_d = IDLE;
              leds_d  = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              step_d  = '0;
            end
          end else begin
            rem_d = rem_q - DUR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
      last_q <= '0;
      loop_q <= 1'b0;
      leds_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rem_q  <= '0;
    end else begin
      step_q <= step_d;
      last_q <= last_d;
      loop_q <= loop_d;
      leds_q <= leds_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rem_q  <= rem_d;
    end
  end

  // Step memory is flops so that reset clears every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we_c) begin
      mem[bus.cfg_addr] <= '{pattern: bus.cfg_pattern, dur: bus.cfg_dur};
    end
  end

  assign bus.leds     = leds_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_idx = step_q;

endmodule
